// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with multiple writeback ports, multi-slot in-order commit and flush.
module rob_multiport #(
  parameter int DEPTH = 8,
  parameter int NUM_WB = 2,
  parameter int COMMIT_W = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       alloc_valid_i,
  input  logic [31:0]                alloc_pc_i,
  input  logic [31:0]                alloc_instr_i,
  input  logic [4:0]                 alloc_rd_i,
  input  logic                       alloc_we_i,
  input  logic                       alloc_store_i,
  input  logic [31:0]                alloc_kid_i,
  output logic [IDX_W-1:0]           alloc_idx_o,
  output logic                       full_o,
  output logic [IDX_W:0]             count_o,
  input  logic [NUM_WB-1:0]          wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0]    wb_idx_i,
  input  logic [NUM_WB*32-1:0]       wb_result_i,
  input  logic [NUM_WB*32-1:0]       wb_new_pc_i,
  input  logic [NUM_WB-1:0]          wb_taken_i,
  input  logic [9:0]                 src_addr_i,
  output logic [1:0]                 src_hazard_o,
  output logic [2*IDX_W-1:0]         src_idx_o,
  output logic [1:0]                 src_done_o,
  output logic [63:0]                src_result_o,
  output logic [COMMIT_W-1:0]        cm_valid_o,
  output logic [COMMIT_W*32-1:0]     cm_pc_o,
  output logic [COMMIT_W*32-1:0]     cm_instr_o,
  output logic [COMMIT_W*5-1:0]      cm_rd_o,
  output logic [COMMIT_W-1:0]        cm_we_o,
  output logic [COMMIT_W-1:0]        cm_store_o,
  output logic [COMMIT_W*32-1:0]     cm_result_o,
  output logic [COMMIT_W*32-1:0]     cm_kid_o,
  output logic                       cm_redirect_o,
  output logic [31:0]                cm_new_pc_o
);
  localparam int CNT_W = IDX_W + 1;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic        store;
    logic [31:0] kid;
  } pay_t;
  pay_t             pay_q [DEPTH];
  logic [31:0]      res_q [DEPTH];
  logic [31:0]      npc_q [DEPTH];
  logic [DEPTH-1:0] valid_q, done_q, taken_q;
  logic [IDX_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, n_cm;
  logic [IDX_W-1:0] slot [COMMIT_W];
  logic [IDX_W-1:0] age [DEPTH];
  logic             run, clear, alloc_ok, dup_wb;
  for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
    assign slot[k] = head_q + IDX_W'(k);
  end
  for (genvar a = 0; a < DEPTH; a++) begin : g_age
    assign age[a] = head_q + IDX_W'(a);
  end
  assign full_o      = count_q == CNT_W'(DEPTH);
  assign count_o     = count_q;
  assign alloc_idx_o = tail_q;
  assign clear       = flush_i || cm_redirect_o;
  assign alloc_ok    = alloc_valid_i && !full_o && !clear;
  // A slot retires only if all older slots retire and none of them redirects.
  always_comb begin
    run = !flush_i;
    n_cm = '0;
    cm_valid_o = '0;
    cm_we_o = '0;
    cm_store_o = '0;
    cm_pc_o = '0;
    cm_instr_o = '0;
    cm_rd_o = '0;
    cm_result_o = '0;
    cm_kid_o = '0;
    cm_redirect_o = 1'b0;
    cm_new_pc_o = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      run = run && valid_q[slot[i]] && done_q[slot[i]];
      if (run) begin
        cm_valid_o[i] = 1'b1;
        cm_we_o[i] = pay_q[slot[i]].we;
        cm_store_o[i] = pay_q[slot[i]].store;
        cm_pc_o[i*32+:32] = pay_q[slot[i]].pc;
        cm_instr_o[i*32+:32] = pay_q[slot[i]].instr;
        cm_rd_o[i*5+:5] = pay_q[slot[i]].rd;
        cm_result_o[i*32+:32] = res_q[slot[i]];
        cm_kid_o[i*32+:32] = pay_q[slot[i]].kid;
        n_cm = n_cm + CNT_W'(1);
        if (taken_q[slot[i]]) begin
          cm_redirect_o = 1'b1;
          cm_new_pc_o = npc_q[slot[i]];
        end
      end
      run = run && !taken_q[slot[i]];
    end
  end
  // Walk oldest to youngest so the last match is the youngest writer.
  always_comb begin
    src_hazard_o = '0;
    src_idx_o = '0;
    src_done_o = '0;
    src_result_o = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (src_addr_i[s*5+:5] != 5'd0 && valid_q[age[i]] && pay_q[age[i]].we &&
            pay_q[age[i]].rd == src_addr_i[s*5+:5]) begin
          src_hazard_o[s] = 1'b1;
          src_idx_o[s*IDX_W+:IDX_W] = age[i];
          src_done_o[s] = done_q[age[i]];
          src_result_o[s*32+:32] = done_q[age[i]] ? res_q[age[i]] : '0;
        end
      end
    end
  end
  always_comb begin
    dup_wb = 1'b0;
    for (int p = 0; p < NUM_WB; p++)
      for (int q = p + 1; q < NUM_WB; q++)
        dup_wb = dup_wb || (wb_valid_i[p] && wb_valid_i[q] &&
                 wb_idx_i[p*IDX_W+:IDX_W] == wb_idx_i[q*IDX_W+:IDX_W]);
  end
  a_no_dup_wb: assert property (@(posedge clk_i) disable iff (!rstn_i) !dup_wb);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q <= '0;
      taken_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pay_q[i] <= '0;
        res_q[i] <= '0;
        npc_q[i] <= '0;
      end
    end else if (clear) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q <= '0;
      taken_q <= '0;
    end else begin
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        taken_q[tail_q] <= 1'b0;
        pay_q[tail_q] <= {alloc_pc_i, alloc_instr_i, alloc_rd_i, alloc_we_i, alloc_store_i, alloc_kid_i};
        tail_q <= tail_q + IDX_W'(1);
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && valid_q[wb_idx_i[p*IDX_W+:IDX_W]]) begin
          done_q[wb_idx_i[p*IDX_W+:IDX_W]] <= 1'b1;
          res_q[wb_idx_i[p*IDX_W+:IDX_W]] <= wb_result_i[p*32+:32];
          npc_q[wb_idx_i[p*IDX_W+:IDX_W]] <= wb_new_pc_i[p*32+:32];
          taken_q[wb_idx_i[p*IDX_W+:IDX_W]] <= wb_taken_i[p];
        end
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (cm_valid_o[i]) begin
          valid_q[slot[i]] <= 1'b0;
          done_q[slot[i]] <= 1'b0;
        end
      end
      head_q <= head_q + n_cm[IDX_W-1:0];
      count_q <= count_q + CNT_W'(alloc_ok) - n_cm;
    end
  end
endmodule
